mem_fill_seq: RTL and testbench
===============================

// Module: mem_fill_seq
// PURPOSE
//  Parametrised memory-fill sequencer for the RC4 S-array, generalising the S[i]=i init loop.
//  Writes every entry 0..DEPTH-1 through the shared-memory arbiter (request/request_finished)
//  with a selectable pattern: identity, constant, reverse or index^value.
//  Sits ahead of the KSA/PRGA loops; a new fill can be restarted per key attempt, or aborted.
// PARAMETERS
//  DATA_W  8    width of each written word
//  DEPTH   256  entries written per fill (2..2**ADDR_W)
//  ADDR_W  8    address width
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       synchronous, active-high
//  start             in   1       begin fill (sampled in IDLE only)
//  mode              in   2       0 identity, 1 constant, 2 reverse, 3 index^fill_value
//  fill_value        in   DATA_W  operand for modes 1 and 3
//  abort             in   1       stop after the in-flight write completes
//  request_finished  in   1       arbiter ack for current write
//  request           out  1       write request to arbiter
//  address           out  ADDR_W  write address
//  data              out  DATA_W  write data
//  busy              out  1       high from LOAD through NEXT
//  finished          out  1       1-cycle pulse in DONE
//  aborted           out  1       valid with finished: 1 if fill was aborted
// BEHAVIOUR
//  Reset: state IDLE; index=0; request, finished, aborted, busy = 0; address=0; data=0.
//  Reset mid-fill: request drops the next cycle, no further writes; arbiter must tolerate.
//  FSM: IDLE -start-> LOAD -> SEND -> WAIT -ack-> NEXT -> SEND | DONE -> IDLE.
//   LOAD: latch mode, fill_value; index=0; clear abort latch.
//   SEND: register address=index, data=f(index); request stays 0.
//   WAIT: request=1; address/data held stable; leave on the cycle request_finished=1
//         (ack in first WAIT cycle allowed). request_finished outside WAIT ignored.
//   NEXT: if index==DEPTH-1 or abort latched -> DONE; else index+=1 -> SEND.
//   DONE: finished=1, aborted=abort latch, one cycle -> IDLE.
//  Pattern f(i), i zero-extended/truncated to DATA_W: mode0 i; mode1 fill_value;
//   mode2 DEPTH-1-i; mode3 i ^ fill_value. Arithmetic mod 2**DATA_W.
//  Latency: per entry = 2 + ack wait cycles; with same-cycle ack, finished is high
//   exactly 3*DEPTH+2 cycles after the cycle start was sampled.
//  start while busy/DONE ignored; mode/fill_value changes after LOAD have no effect.
//  abort: latched on any cycle in LOAD..NEXT; in-flight write (SEND/WAIT) always completes
//   and is acked; abort in IDLE/DONE ignored. abort in same cycle as last NEXT -> aborted=1.
//  index never wraps: stops at DEPTH-1; no write beyond DEPTH-1.
//  busy=0 in IDLE and DONE; address/data retain last value in IDLE.
// TESTING
//  mode0, DEPTH=256, ack same cycle as request -> writes addr k data k, k=0..255; finished at +770, aborted=0.
//  mode1 fill_value=8'hA5, ack 3 cycles late -> every write data A5; address/data stable while request=1.
//  mode2 and mode3 fill_value=8'h0F, DEPTH=16 -> data 15-k / k^0F for k=0..15; exactly 16 requests.
//  abort pulsed during WAIT of entry 5 -> entry 5 write completes, no entry 6; finished=1 with aborted=1.
//  reset asserted during WAIT of entry 100 -> next cycle request=0, busy=0, address=0; new start refills from 0.
//  start held high through fill and in DONE -> no restart until back in IDLE; second fill starts at index 0.

Source files
------------

// File: rtl/mem_fill_seq.sv
// Pattern fill sequencer: writes entries 0..DEPTH-1 through the shared-memory arbiter, one entry per SEND/WAIT/NEXT.
// Latency is 2 + ack-wait cycles per entry; the arbiter stalls us by withholding request_finished.
module mem_fill_seq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  input  logic              request_finished,
  output logic              request,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              finished,
  output logic              aborted
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] NEXT = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] LAST_DATA = DATA_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] index;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic              abort_lat;
  logic [DATA_W-1:0] pattern;

  always_comb begin
    pattern = DATA_W'(index);
    case (mode_q)
      2'd0:    pattern = DATA_W'(index);
      2'd1:    pattern = fill_q;
      2'd2:    pattern = LAST_DATA - DATA_W'(index);
      default: pattern = DATA_W'(index) ^ fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      mode_q    <= '0;
      fill_q    <= '0;
      abort_lat <= 1'b0;
      address   <= '0;
      data      <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: begin
          mode_q    <= mode;
          fill_q    <= fill_value;
          index     <= '0;
          abort_lat <= abort;
          state     <= SEND;
        end
        SEND: begin
          address <= index;
          data    <= pattern;
          if (abort) abort_lat <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (abort) abort_lat <= 1'b1;
          if (request_finished) state <= NEXT;
        end
        NEXT: begin
          // An abort arriving here still lands in DONE with aborted set, even on the last entry.
          if (abort) abort_lat <= 1'b1;
          if (index == LAST_IDX || abort_lat || abort) begin
            state <= DONE;
          end else begin
            index <= index + 1'b1;
            state <= SEND;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign request  = (state == WAIT);
  assign busy     = (state == LOAD) || (state == SEND) || (state == WAIT) || (state == NEXT);
  assign finished = (state == DONE);
  assign aborted  = (state == DONE) && abort_lat;

endmodule

// File: tb/tb_mem_fill_seq.sv
// Directed bench for mem_fill_seq: a 256-entry instance (a) and a 16-entry instance (b) with
// a programmable-delay arbiter model and a write monitor per instance.
module tb_mem_fill_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] fill_value = 8'h00;
  logic       abort = 1'b0;
  logic       ack_a, ack_b;
  logic       req_a, req_b, busy_a, busy_b, fin_a, fin_b, ab_a, ab_b;
  logic [7:0] addr_a, addr_b, data_a, data_b;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  int wcnt_a = 0, wcnt_b = 0;

  mem_fill_seq #(.DATA_W(8), .DEPTH(256), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode), .fill_value(fill_value),
    .abort(abort), .request_finished(ack_a), .request(req_a), .address(addr_a),
    .data(data_a), .busy(busy_a), .finished(fin_a), .aborted(ab_a));

  mem_fill_seq #(.DATA_W(8), .DEPTH(16), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode), .fill_value(fill_value),
    .abort(abort), .request_finished(ack_b), .request(req_b), .address(addr_b),
    .data(data_b), .busy(busy_b), .finished(fin_b), .aborted(ab_b));

  // Arbiter model: ack is raised ack_delay cycles into the request (0 = same cycle).
  assign ack_a = req_a && (wcnt_a >= ack_delay);
  assign ack_b = req_b && (wcnt_b >= ack_delay);

  logic [7:0] aq_a[$], dq_a[$], aq_b[$], dq_b[$];
  logic       prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] ha_a, hd_a, ha_b, hd_b;
  int         stab_a = 0, stab_b = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (req_a && !prev_a) begin
        aq_a.push_back(addr_a); dq_a.push_back(data_a); ha_a = addr_a; hd_a = data_a;
      end else if (req_a && (addr_a !== ha_a || data_a !== hd_a)) stab_a++;
      if (req_b && !prev_b) begin
        aq_b.push_back(addr_b); dq_b.push_back(data_b); ha_b = addr_b; hd_b = data_b;
      end else if (req_b && (addr_b !== ha_b || data_b !== hd_b)) stab_b++;
      prev_a = req_a;
      prev_b = req_b;
      if (!req_a) wcnt_a = 0; else if (!ack_a) wcnt_a++;
      if (!req_b) wcnt_b = 0; else if (!ack_b) wcnt_b++;
    end
  end

  task automatic clear_queues();
    aq_a.delete(); dq_a.delete(); aq_b.delete(); dq_b.delete();
    stab_a = 0; stab_b = 0;
  endtask

  // Pulses start for one cycle and counts edges from the sampling edge (1) until finished is seen.
  task automatic run_fill(input int sel, input logic [1:0] m, input logic [7:0] fv,
                          output int cyc, output logic ab);
    @(negedge clk);
    mode = m; fill_value = fv;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk); start_a = 1'b0; start_b = 1'b0;
    end while (!(sel == 0 ? fin_a : fin_b) && cyc < 20000);
    ab = (sel == 0) ? ab_a : ab_b;
    if (cyc >= 20000) begin
      checks++; errors++;
      $display("FAIL run_fill_timeout: finished not seen after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_a !== 1'b0)   begin errors++; $display("FAIL reset_request: got %b want 0", req_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (fin_a !== 1'b0 || ab_a !== 1'b0) begin errors++; $display("FAIL reset_finished: got %b/%b want 0/0", fin_a, ab_a); end
    checks++; if (addr_a !== 8'h00 || data_a !== 8'h00) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 00/00", addr_a, data_a); end
    checks++; if (busy_b !== 1'b0 || req_b !== 1'b0) begin errors++; $display("FAIL reset_b: busy/req %b/%b want 0/0", busy_b, req_b); end
    reset = 1'b0;
  endtask

  task automatic test_identity();
    int cyc; logic ab; int bad = 0;
    ack_delay = 0; clear_queues();
    run_fill(0, 2'd0, 8'h00, cyc, ab);
    checks++; if (cyc !== 770) begin errors++; $display("FAIL identity_latency: got %0d want 770", cyc); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL identity_aborted: got %b want 0", ab); end
    checks++; if (aq_a.size() !== 256) begin errors++; $display("FAIL identity_count: got %0d want 256", aq_a.size()); end
    for (int k = 0; k < aq_a.size() && k < 256; k++)
      if (aq_a[k] !== 8'(k) || dq_a[k] !== 8'(k)) begin
        if (bad == 0) $display("FAIL identity_entry%0d: got addr %h data %h want %h/%h", k, aq_a[k], dq_a[k], 8'(k), 8'(k));
        bad++;
      end
    checks++; if (bad != 0) begin errors++; $display("FAIL identity_entries: %0d bad entries want 0", bad); end
  endtask

  task automatic test_constant_slow_ack();
    int cyc; logic ab; int bad = 0;
    ack_delay = 3; clear_queues();
    run_fill(1, 2'd1, 8'hA5, cyc, ab);
    checks++; if (aq_b.size() !== 16) begin errors++; $display("FAIL const_count: got %0d want 16", aq_b.size()); end
    for (int k = 0; k < aq_b.size(); k++)
      if (aq_b[k] !== 8'(k) || dq_b[k] !== 8'hA5) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL const_entries: %0d bad entries want 0", bad); end
    checks++; if (stab_b != 0) begin errors++; $display("FAIL const_stability: %0d changes while request high, want 0", stab_b); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL const_aborted: got %b want 0", ab); end
  endtask

  task automatic test_reverse_xor();
    int cyc; logic ab; int bad;
    logic [7:0] exp_d;
    ack_delay = 0;
    for (int m = 2; m <= 3; m++) begin
      clear_queues(); bad = 0;
      run_fill(1, 2'(m), 8'h0F, cyc, ab);
      checks++; if (aq_b.size() !== 16) begin errors++; $display("FAIL mode%0d_count: got %0d want 16", m, aq_b.size()); end
      checks++; if (cyc !== 50) begin errors++; $display("FAIL mode%0d_latency: got %0d want 50", m, cyc); end
      for (int k = 0; k < aq_b.size(); k++) begin
        exp_d = (m == 2) ? 8'(15 - k) : (8'(k) ^ 8'h0F);
        if (aq_b[k] !== 8'(k) || dq_b[k] !== exp_d) begin
          if (bad == 0) $display("FAIL mode%0d_entry%0d: got %h/%h want %h/%h", m, k, aq_b[k], dq_b[k], 8'(k), exp_d);
          bad++;
        end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mode%0d_entries: %0d bad want 0", m, bad); end
    end
  endtask

  task automatic test_abort();
    int cyc; logic ab;
    ack_delay = 3; clear_queues();
    fork
      run_fill(1, 2'd0, 8'h00, cyc, ab);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!(req_b && addr_b == 8'd5) && n < 2000);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
      end
    join
    checks++; if (ab !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b want 1", ab); end
    checks++; if (aq_b.size() !== 6) begin errors++; $display("FAIL abort_count: got %0d writes want 6", aq_b.size()); end
    checks++; if (aq_b.size() > 0 && aq_b[aq_b.size()-1] !== 8'd5) begin errors++; $display("FAIL abort_last: got %h want 05", aq_b[aq_b.size()-1]); end
  endtask

  task automatic test_reset_mid_fill();
    int cyc; logic ab; int n = 0;
    ack_delay = 0; clear_queues();
    @(negedge clk); mode = 2'd0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    while (!(req_a && addr_a == 8'd100) && n < 2000) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL midreset_req_busy: got %b/%b want 0/0", req_a, busy_a); end
    checks++; if (addr_a !== 8'h00) begin errors++; $display("FAIL midreset_addr: got %h want 00", addr_a); end
    reset = 1'b0;
    clear_queues();
    run_fill(0, 2'd0, 8'h00, cyc, ab);
    checks++; if (aq_a.size() !== 256 || aq_a[0] !== 8'h00) begin errors++; $display("FAIL midreset_refill: got %0d writes first %h want 256 first 00", aq_a.size(), aq_a[0]); end
    checks++; if (cyc !== 770) begin errors++; $display("FAIL midreset_latency: got %0d want 770", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    ack_delay = 0; clear_queues();
    @(negedge clk); mode = 2'd0; start_b = 1'b1;
    do begin @(posedge clk); cyc++; @(negedge clk); end while (!fin_b && cyc < 2000);
    checks++; if (cyc !== 50) begin errors++; $display("FAIL b2b_latency: got %0d want 50", cyc); end
    checks++; if (aq_b.size() !== 16) begin errors++; $display("FAIL b2b_first_count: got %0d want 16", aq_b.size()); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_done_busy: got %b want 0", busy_b); end
    clear_queues();
    @(negedge clk);
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy_b); end
    @(negedge clk);
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b want 1", busy_b); end
    start_b = 1'b0;
    cyc = 0;
    do begin @(posedge clk); cyc++; @(negedge clk); end while (!fin_b && cyc < 2000);
    checks++; if (aq_b.size() !== 16 || aq_b[0] !== 8'h00 || aq_b[15] !== 8'h0F) begin
      errors++; $display("FAIL b2b_second_fill: got %0d writes first %h last %h want 16/00/0f", aq_b.size(), aq_b[0], aq_b[15]);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_constant_slow_ack();
    test_reverse_xor();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
